bp_fe_queue_sender: RTL
=======================

Name: bp_fe_queue_sender

Overview:
FE-side transmitter for the FE->BE fetch queue interface. It accepts fetch results and fetch exceptions from the FE pipeline and packs them into bp_fe_queue_s packets. Packets are held in a small in-order output buffer and driven to the BE issue queue over a valid/ready handshake.
After sending an exception packet, it stops accepting new work until the FE is redirected (flush). It also supports a full-drop flush on redirect.

Parameters:
bp_params_p, e_bp_multicore_1_cfg, processor config; supplies vaddr_width_p, branch_metadata_fwd_width_p and fe_queue_width_lp.
buf_els_p, 2, output buffer depth; power of two, ≥2.
ptr_width_lp, `BSG_SAFE_CLOG2(buf_els_p), derived local; buffer pointer width without the wrap bit.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
flush_i  in  1  redirect/flush from the FE command path; drops all buffered packets and clears HOLD.
fetch_v_i  in  1  fetch/exception item valid
fetch_ready_o  out  1  item accepted when fetch_v_i & fetch_ready_o
fetch_exception_i  in  1  1 = the item is an exception, 0 = a normal fetch.
fetch_exception_code_i  in  2  1 itlb_miss, 2 instr_page_fault, 3 instr_access_fault; ignored unless fetch_exception_i.
fetch_pc_i  in  vaddr_width_p  PC of the item
fetch_instr_i  in  32  instruction word; forced to 0 for exceptions.
fetch_br_metadata_i  in  branch_metadata_fwd_width_p  branch metadata; forced to 0 for exceptions.
fe_queue_o  out  fe_queue_width_lp  packed bp_fe_queue_s
fe_queue_v_o  out  1  packet valid
fe_queue_ready_i  in  1  BE issue queue ready; transfer = fe_queue_v_o & fe_queue_ready_i.
busy_o  out  1  buffer non-empty or FSM in HOLD

Behaviour:
- Reset (async assert, sync release): buffer empty, rptr=wptr=0 (with wrap bits), FSM=RUN. Output reset values: fe_queue_v_o=0, fe_queue_o=0, busy_o=0, fetch_ready_o=1 once reset deasserts.
- Packet formation:
  - Fetch packet: msg_type=e_fe_fetch, pc, instr, branch_metadata_fwd.
  - Exception packet: msg_type=e_fe_exception, pc, exception_code. The instr and metadata fields are zero.
  - Unused fields are zero.
- Buffer structure: circular, buf_els_p entries, rptr/wptr of ptr_width_lp+1 bits (wrap bit).
  - empty = (rptr==wptr).
  - full = low bits equal and wrap bits differ.
- Buffer is registered, with no input-to-output bypass.
  - An item accepted in cycle N appears on fe_queue_o/fe_queue_v_o in cycle N+1 at the earliest.
  - fe_queue_o shows the entry at rptr.
- fetch_ready_o = ~full & ~flush_i & (state==RUN).
  - No combinational dependence on fe_queue_ready_i.
  - When full, ready stays low even if a dequeue happens in the same cycle.
- fe_queue_v_o = ~empty & ~flush_i.
- Per-cycle pointer update:
  - enq advances wptr by 1; deq advances rptr by 1.
  - Simultaneous enq and deq are both legal and leave occupancy unchanged.
- FSM:
  - RUN -> HOLD when an accepted item has fetch_exception_i=1. The exception packet itself is enqueued.
  - HOLD: fetch_ready_o=0. Already-buffered packets, including the exception, continue to drain.
  - HOLD -> RUN only on flush_i.
  - flush_i in RUN stays in RUN.
- flush_i (single-cycle pulse, may also be held):
  - That cycle: no enqueue, no transfer (valid forced low).
  - Next edge: wptr <= rptr (buffer empty), FSM=RUN.
  - Cycle after flush deasserts: fetch_ready_o=1.
- Wrap-around: pointers wrap modulo 2*buf_els_p. Full/empty must be correct across any number of wraps.
- busy_o = ~empty | (state==HOLD).
- Assertions (simulation only):
  - fe_queue_o is stable while fe_queue_v_o & ~fe_queue_ready_i & ~flush_i.
  - No enqueue when full.
  - fetch_exception_code_i != 0 when fetch_exception_i.

Test Plan:
- Reset, then 3 fetches (pc 0x1000/0x1004/0x1008) with fe_queue_ready_i=1 -> three packets in order, each 1 cycle after acceptance; fetch_ready_o never drops.
- fe_queue_ready_i=0, offer 3 items (buf_els_p=2) -> first 2 accepted, then fetch_ready_o=0. Raise ready -> packets drain 0x1000, 0x1004; third item accepted the cycle after the first dequeue.
- Exception, code 2, at pc 0x2000 -> packet with msg_type=exception, instr=0, code=2. fetch_ready_o stays 0 after drain, busy_o=1 until flush_i; fetch_ready_o=1 the cycle after flush.
- Buffer holds 2 entries, flush_i pulsed with fe_queue_ready_i=1 and fetch_v_i=1 -> no transfer, no accept that cycle; buffer empty next cycle; fe_queue_v_o=0.
- 20 back-to-back fetches with ready toggling 1/0 every cycle -> no loss or duplication, strict pc order, at least 5 pointer wraps.
- Assert reset_i mid-stream with 2 entries buffered -> fe_queue_v_o=0 immediately (async), state RUN, pointers 0 after release.

Source files
------------

// File: rtl/bp_fe_queue_sender_if.sv
// FE fetch-side inputs and FE->BE queue handshake for bp_fe_queue_sender.
// master = the sender, slave = its environment (FE pipeline and BE issue queue).
interface bp_fe_queue_sender_if #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 36
);
  // Packet layout, MSB first: msg_type, pc, instr, branch_metadata_fwd, exception_code.
  localparam int fe_queue_width_lp = 1 + vaddr_width_p + 32 + branch_metadata_fwd_width_p + 2;

  logic                                   flush_i;
  logic                                   fetch_v_i;
  logic                                   fetch_ready_o;
  logic                                   fetch_exception_i;
  logic [1:0]                             fetch_exception_code_i;
  logic [vaddr_width_p-1:0]               fetch_pc_i;
  logic [31:0]                            fetch_instr_i;
  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i;
  logic [fe_queue_width_lp-1:0]           fe_queue_o;
  logic                                   fe_queue_v_o;
  logic                                   fe_queue_ready_i;
  logic                                   busy_o;

  modport master (
    input  flush_i, fetch_v_i, fetch_exception_i, fetch_exception_code_i,
           fetch_pc_i, fetch_instr_i, fetch_br_metadata_i, fe_queue_ready_i,
    output fetch_ready_o, fe_queue_o, fe_queue_v_o, busy_o
  );

  modport slave (
    output flush_i, fetch_v_i, fetch_exception_i, fetch_exception_code_i,
           fetch_pc_i, fetch_instr_i, fetch_br_metadata_i, fe_queue_ready_i,
    input  fetch_ready_o, fe_queue_o, fe_queue_v_o, busy_o
  );
endinterface

// File: rtl/bp_fe_queue_sender.sv
// FE->BE fetch queue transmitter: packs fetches/exceptions into packets, buffers them
// in a small registered circular FIFO, and blocks new work after an exception until flush.
module bp_fe_queue_sender #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 36,
  parameter int buf_els_p                   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_fe_queue_sender_if.master  fe_if
);
  localparam int ptr_width_lp = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;

  typedef enum logic {e_fe_fetch = 1'b0, e_fe_exception = 1'b1} fe_msg_type_e;
  typedef enum logic {e_run = 1'b0, e_hold = 1'b1} state_e;

  typedef struct packed {
    fe_msg_type_e                           msg_type;
    logic [vaddr_width_p-1:0]               pc;
    logic [31:0]                            instr;
    logic [branch_metadata_fwd_width_p-1:0] br_metadata;
    logic [1:0]                             exception_code;
  } fe_queue_s;

  logic [ptr_width_lp:0] rptr_q, rptr_d, wptr_q, wptr_d;
  state_e                state_q, state_d;
  fe_queue_s             buf_q [buf_els_p];
  fe_queue_s             pkt;
  logic                  empty, full, enq, deq;

  assign empty = (rptr_q == wptr_q);
  assign full  = (rptr_q[ptr_width_lp-1:0] == wptr_q[ptr_width_lp-1:0])
               & (rptr_q[ptr_width_lp] != wptr_q[ptr_width_lp]);

  // Ready never looks at fe_queue_ready_i, so a full buffer stays closed for one cycle after a dequeue.
  assign fe_if.fetch_ready_o = ~full & ~fe_if.flush_i & (state_q == e_run);
  assign fe_if.fe_queue_v_o  = ~empty & ~fe_if.flush_i;
  assign fe_if.fe_queue_o    = empty ? '0 : buf_q[rptr_q[ptr_width_lp-1:0]];
  assign fe_if.busy_o        = ~empty | (state_q == e_hold);

  assign enq = fe_if.fetch_v_i & fe_if.fetch_ready_o;
  assign deq = fe_if.fe_queue_v_o & fe_if.fe_queue_ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pkt    = '0;
    pkt.pc = fe_if.fetch_pc_i;
    if (fe_if.fetch_exception_i) begin
      pkt.msg_type       = e_fe_exception;
      pkt.exception_code = fe_if.fetch_exception_code_i;
    end else begin
      pkt.msg_type    = e_fe_fetch;
      pkt.instr       = fe_if.fetch_instr_i;
      pkt.br_metadata = fe_if.fetch_br_metadata_i;
    end
  end

  always_comb begin
    rptr_d = rptr_q + {{ptr_width_lp{1'b0}}, deq};
    wptr_d = fe_if.flush_i ? rptr_q : wptr_q + {{ptr_width_lp{1'b0}}, enq};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_run:   if (enq && fe_if.fetch_exception_i) state_d = e_hold;
      e_hold:  if (fe_if.flush_i) state_d = e_run;
      default: state_d = e_run;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      state_q <= e_run;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      state_q <= state_d;
    end
  end

  // NOTE: packet storage is not reset; the read port is gated by empty, so stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (enq) buf_q[wptr_q[ptr_width_lp-1:0]] <= pkt;
  end

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (fe_if.fe_queue_v_o & ~fe_if.fe_queue_ready_i & ~fe_if.flush_i) |=> $stable(fe_if.fe_queue_o));
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i) enq |-> ~full);
  a_exc_code: assert property (@(posedge clk_i) disable iff (reset_i)
    (fe_if.fetch_v_i & fe_if.fetch_exception_i) |-> (fe_if.fetch_exception_code_i != 2'b00));
`endif
endmodule
